// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: latches one request, runs a single access (byte stores as read-modify-write).
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module dm_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          byte0,
  input  logic          byte1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRB} state_t;

  state_t        state, next;
  logic          owner;
  logic          win;
  logic          l_we, l_byte;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] merge;
  logic          done;
  logic [DW-1:0] rdata_int;

`ifdef DM_ARB_RR_EN
  // last holds the previous owner; reset value 1 makes requester 0 win first contention
  logic last;

  always_comb win = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clock) begin
    if (reset) last <= 1'b1;
    else if (done) last <= owner;
  end
`else
  always_comb win = ~req0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      l_we    <= 1'b0;
      l_byte  <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      merge   <= '0;
    end else begin
      state <= next;
      if (state == IDLE && (req0 || req1)) begin
        owner   <= win;
        l_we    <= win ? we1 : we0;
        l_byte  <= win ? byte1 : byte0;
        l_addr  <= win ? addr1 : addr0;
        l_wdata <= win ? wdata1 : wdata0;
      end
      if (state == ACCESS && l_we && l_byte)
        merge <= {mem_dout[DW-1:8], l_wdata[7:0]};
    end
  end

  always_comb begin
    next      = state;
    mem_addr  = '0;
    mem_din   = '0;
    mem_we    = 1'b0;
    done      = 1'b0;
    rdata_int = '0;
    case (state)
      IDLE: if (req0 || req1) next = ACCESS;
      ACCESS: begin
        mem_addr = l_addr;
        if (l_we && l_byte) begin
          next = WRB;
        end else begin
          next = IDLE;
          done = 1'b1;
          if (l_we) begin
            mem_we  = 1'b1;
            mem_din = l_wdata;
          end else if (l_byte) begin
            rdata_int = {{(DW-8){mem_dout[7]}}, mem_dout[7:0]};
          end else begin
            rdata_int = mem_dout;
          end
        end
      end
      WRB: begin
        mem_addr = l_addr;
        mem_din  = merge;
        mem_we   = 1'b1;
        done     = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
    // reset aborts an in-flight access before anything is committed or granted
    if (reset) begin
      mem_we = 1'b0;
      done   = 1'b0;
    end
  end

  always_comb begin
    gnt0   = done && !owner;
    gnt1   = done && owner;
    rdata0 = gnt0 ? rdata_int : '0;
    rdata1 = gnt1 ? rdata_int : '0;
    busy   = (state != IDLE);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed cases from the test plan plus randomized two-requester batches.
`timescale 1ns/1ps
module tb_dm_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, byte0, byte1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic          busy;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .byte0(byte0), .byte1(byte1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clock = ~clock;

  // data memory: combinational read, write on rising edge; bench preload port used only while idle
  logic [31:0] mem [0:4095];
  logic        tb_we;
  logic [11:0] tb_addr;
  logic [31:0] tb_din;
  assign mem_dout = mem[mem_addr];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    else if (tb_we) mem[tb_addr] <= tb_din;
  end

  typedef struct packed {
    logic        we;
    logic        bt;
    logic [11:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  op_t         pend0[$];
  op_t         pend1[$];
  logic [31:0] refm [0:4095];
  logic        model_last;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned we_seen = 0;
  int unsigned we_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference model: whole-access semantics on a word array
  function automatic void model_apply(input int r, input op_t o);
    exp_t        e;
    logic [31:0] w;
    w = refm[o.addr];
    e.id = (r == 1);
    e.rdata = '0;
    if (o.we) begin
      refm[o.addr] = o.bt ? {w[31:8], o.wdata[7:0]} : o.wdata;
      we_exp++;
    end else begin
      e.rdata = o.bt ? 32'($signed(w[7:0])) : w;
    end
    model_last = (r == 1);
    sb.push_back(e);
  endfunction

  function automatic void model_batch();
    op_t c0[$];
    op_t c1[$];
    int  w;
    c0 = pend0;
    c1 = pend1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) begin
`ifdef DM_ARB_RR_EN
        w = model_last ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = (c0.size() > 0) ? 0 : 1;
      end
      if (w == 0) model_apply(0, c0.pop_front());
      else model_apply(1, c1.pop_front());
    end
  endfunction

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 12'($urandom_range(0, 63));
    return 12'(12'hFC0 + $urandom_range(0, 63));
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we    = 1'($urandom_range(0, 1));
    o.bt    = 1'($urandom_range(0, 1));
    o.addr  = rand_addr();
    o.wdata = $urandom;
    return o;
  endfunction

  task automatic present(input int r, input op_t o);
    if (r == 0) begin
      req0 = 1'b1; we0 = o.we; byte0 = o.bt; addr0 = o.addr; wdata0 = o.wdata;
    end else begin
      req1 = 1'b1; we1 = o.we; byte1 = o.bt; addr1 = o.addr; wdata1 = o.wdata;
    end
  endtask

  task automatic release_req(input int r);
    if (r == 0) begin
      req0 = 1'b0; addr0 = 12'($urandom); wdata0 = $urandom;
    end else begin
      req1 = 1'b0; addr1 = 12'($urandom); wdata1 = $urandom;
    end
  endtask

  task automatic tb_write(input logic [11:0] a, input logic [31:0] d);
    tb_addr = a; tb_din = d; tb_we = 1'b1;
    @(posedge clock); #1;
    tb_we = 1'b0;
    refm[a] = d;
  endtask

  // single uncontended access; latency counted in cycles after the sampling edge
  task automatic do_op(input int r, input op_t o, input int unsigned lat_exp, input string name);
    int unsigned lat;
    int unsigned we_at;
    logic        got;
    model_apply(r, o);
    @(posedge clock); #1;
    present(r, o);
    @(posedge clock);
    lat = 0; we_at = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clock);
      lat++;
      if (mem_we) we_at = lat;
      got = (r == 0) ? gnt0 : gnt1;
    end
    check(name, lat, lat_exp);
    if (o.we) check({name, "_we_cycle"}, we_at, lat_exp);
    @(posedge clock); #1;
    release_req(r);
  endtask

  task automatic run_batch();
    logic        g0, g1;
    int unsigned cyc;
    model_batch();
    @(posedge clock); #1;
    if (pend0.size() > 0) present(0, pend0[0]);
    if (pend1.size() > 0) present(1, pend1[0]);
    cyc = 0;
    while ((req0 || req1) && cyc < 400) begin
      @(negedge clock);
      g0 = gnt0;
      g1 = gnt1;
      @(posedge clock); #1;
      cyc++;
      if (g0) begin
        pend0.delete(0);
        if (pend0.size() > 0) present(0, pend0[0]); else release_req(0);
      end
      if (g1) begin
        pend1.delete(0);
        if (pend1.size() > 0) present(1, pend1[0]); else release_req(1);
      end
    end
    if (req0 || req1) begin
      check("batch_timeout", 32'd1, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      pend0.delete(); pend1.delete();
    end
  endtask

  // monitor: pops the scoreboard on every grant
  exp_t mon_e;
  always @(negedge clock) begin
    if (mem_we) we_seen++;
    if (gnt0 || gnt1) begin
      check("gnt_onehot", {31'b0, gnt0 & gnt1}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_gnt", {31'b0, gnt1}, 32'hFFFFFFFF);
      end else begin
        mon_e = sb.pop_front();
        check("gnt_owner", {31'b0, gnt1}, {31'b0, mon_e.id});
        check("rdata_owner", mon_e.id ? rdata1 : rdata0, mon_e.rdata);
        check("rdata_nonowner", mon_e.id ? rdata0 : rdata1, 32'd0);
      end
    end
  end

  op_t         o;
  int unsigned we_before;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; byte0 = 1'b0; byte1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tb_we = 1'b0; tb_addr = '0; tb_din = '0;
    model_last = 1'b1;
    for (int unsigned i = 0; i < 64; i++) begin
      tb_write(12'(i), 32'd0);
      tb_write(12'(12'hFC0 + i), 32'd0);
    end
    reset = 1'b0;

    @(negedge clock);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_gnt0", {31'b0, gnt0}, 32'd0);
    check("rst_gnt1", {31'b0, gnt1}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);

    // word store then load, requester 0
    we_before = we_seen;
    o = '{we: 1'b1, bt: 1'b0, addr: 12'h010, wdata: 32'hDEADBEEF};
    do_op(0, o, 1, "wstore_lat");
    check("wstore_we_pulses", we_seen - we_before, 32'd1);
    o = '{we: 1'b0, bt: 1'b0, addr: 12'h010, wdata: 32'h0};
    do_op(0, o, 1, "wload_lat");

    // byte store read-modify-write, requester 1
    tb_write(12'h020, 32'h11223344);
    we_before = we_seen;
    o = '{we: 1'b1, bt: 1'b1, addr: 12'h020, wdata: 32'h000000A5};
    do_op(1, o, 2, "bstore_lat");
    check("bstore_we_pulses", we_seen - we_before, 32'd1);
    check("bstore_mem", mem[12'h020], 32'h112233A5);
    o = '{we: 1'b0, bt: 1'b0, addr: 12'h020, wdata: 32'h0};
    do_op(1, o, 1, "bstore_readback_lat");

    // byte load sign extension
    tb_write(12'h024, 32'h000000F0);
    tb_write(12'h028, 32'h0000007F);
    o = '{we: 1'b0, bt: 1'b1, addr: 12'h024, wdata: 32'h0};
    do_op(0, o, 1, "bload_neg_lat");
    o = '{we: 1'b0, bt: 1'b1, addr: 12'h028, wdata: 32'h0};
    do_op(1, o, 1, "bload_pos_lat");

    // contention: both requesters held busy
    for (int unsigned i = 0; i < 4; i++)
      pend0.push_back('{we: 1'b0, bt: 1'b0, addr: 12'(12'h010 + 4 * i), wdata: 32'h0});
    for (int unsigned i = 0; i < 2; i++)
      pend1.push_back('{we: 1'b1, bt: 1'b0, addr: 12'(12'h038 + i), wdata: 32'hA0000000 + i});
    run_batch();

    // reset during the write phase of a byte store
    tb_write(12'h030, 32'hCAFEBABE);
    we_before = we_seen;
    present(1, '{we: 1'b1, bt: 1'b1, addr: 12'h030, wdata: 32'h0000005A});
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rstwrb_mem_we", {31'b0, mem_we}, 32'd0);
    check("rstwrb_gnt1", {31'b0, gnt1}, 32'd0);
    @(posedge clock); #1;
    release_req(1);
    reset = 1'b0;
    model_last = 1'b1;
    @(negedge clock);
    check("rstwrb_busy_after", {31'b0, busy}, 32'd0);
    check("rstwrb_no_write", we_seen - we_before, 32'd0);
    check("rstwrb_mem", mem[12'h030], 32'hCAFEBABE);

    // idle bus
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_mem_we", {31'b0, mem_we}, 32'd0);
      check("idle_gnt", {30'b0, gnt1, gnt0}, 32'd0);
      check("idle_mem_addr", {20'b0, mem_addr}, 32'd0);
    end
    @(posedge clock); #1;

    // randomized batches
    for (int unsigned b = 0; b < 30; b++) begin
      for (int unsigned i = 0; i < $urandom_range(0, 3); i++) pend0.push_back(rand_op());
      for (int unsigned i = 0; i < $urandom_range(0, 3); i++) pend1.push_back(rand_op());
      run_batch();
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
    end

    repeat (3) @(posedge clock);
    #1;
    for (int unsigned i = 0; i < 64; i++) begin
      check("final_mem_lo", mem[12'(i)], refm[12'(i)]);
      check("final_mem_hi", mem[12'(12'hFC0 + i)], refm[12'(12'hFC0 + i)]);
    end
    check("total_mem_writes", we_seen, we_exp);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter/sequencer that shares the single data memory (12-bit address, 32-bit word, combinational read, write on rising clock edge) between requester 0 (the multi-cycle core's load/store path) and requester 1 (a loader/debug or DMA master). It latches a winning request, drives the memory for one access, performs byte stores as a read-modify-write, and returns a one-cycle grant with read data. It sits between the core datapath and `dm`, replacing the direct connection.

## Interface
- `AW`, 12: memory address width.
- `DW`, 32: data width; byte lane is always bits [7:0].
- `clock  in  1  system clock, all state updates on rising edge`
- `reset  in  1  synchronous, active-high`
- `req0 / req1  in  1  access request; hold until gnt, then drop`
- `we0 / we1  in  1  1 = store, 0 = load`
- `byte0 / byte1  in  1  1 = byte access (bits [7:0]), 0 = word`
- `addr0 / addr1  in  AW  access address`
- `wdata0 / wdata1  in  DW  store data`
- `gnt0 / gnt1  out  1  one-cycle pulse: access complete`
- `rdata0 / rdata1  out  DW  load data, valid only while matching gnt high`
- `mem_addr  out  AW  memory address`
- `mem_din  out  DW  memory write data`
- `mem_we  out  1  memory write enable`
- `mem_dout  in  DW  memory combinational read data`
- `busy  out  1  high in any state other than IDLE`

## Operation
- States: IDLE, ACCESS, WRB (byte-write second phase).
- IDLE: if any req high, pick a winner (see Configuration), latch its we/byte/addr/wdata and the owner id, go to ACCESS. No req: stay IDLE.
- ACCESS: `mem_addr` = latched addr.
  - Word load: gnt(owner)=1, rdata(owner)=mem_dout; -> IDLE.
  - Byte load: gnt(owner)=1, rdata(owner)={{24{mem_dout[7]}},mem_dout[7:0]}; -> IDLE.
  - Word store: mem_we=1, mem_din=latched wdata, gnt(owner)=1; -> IDLE.
  - Byte store: mem_we=0; register merge word {mem_dout[31:8], wdata[7:0]}; -> WRB.
- WRB: mem_addr = latched addr, mem_din = merge word, mem_we=1, gnt(owner)=1; -> IDLE.
- Non-owner gnt and rdata are 0 at all times. Outputs in IDLE: mem_we=0, mem_addr=0, mem_din=0, gnt=0, rdata=0.
- Requests arriving while busy are held by the requester and considered only in IDLE.
- Latched fields isolate the access from requester input changes after arbitration.

## Timing
- Reset (reset high at an edge): state=IDLE, owner=0, RR pointer prefers requester 0, merge register=0, all outputs 0. Reset in ACCESS or WRB aborts the access: no gnt, and mem_we is forced 0 while reset is high, so a pending byte store is never committed.
- Latency from req sampled in IDLE at edge N: word access/load gnt in cycle N+1; byte store gnt in N+2.
- Minimum spacing: one IDLE cycle between accesses (throughput 1 word access per 2 cycles).
- Handshake: requester keeps req and all fields stable until gnt; must drive req low in the cycle after gnt unless issuing a new access. A req high in IDLE is always treated as a new access.
- Simultaneous req0 and req1 in IDLE: resolved by the arbitration policy; loser waits, its req stays high.
- Address is passed through unaltered (no wrap or bounds check); upper bits beyond AW do not exist.

## Configuration
- `DM_ARB_RR_EN` defined: round-robin. 1-bit pointer records last owner; on contention the other requester wins; pointer updates on every gnt. Neither requester waits for more than one foreign access.
- Undefined: fixed priority, requester 0 always wins contention; pointer logic absent; requester 1 may starve while req0 stays busy.

## Test plan
- Word store then load by requester 0: addr=0x010, wdata=0xDEADBEEF, store -> gnt0 in N+1, mem_we one cycle; load -> gnt0 with rdata0=0xDEADBEEF.
- Byte store RMW: memory word 0x11223344 at 0x020, requester 1 byte store wdata=0x000000A5 -> mem_we only in WRB (N+2), word becomes 0x112233A5, gnt1 in N+2.
- Byte load sign extension: word 0x000000F0 -> rdata=0xFFFFFFF0; word 0x7F -> 0x0000007F.
- Contention with `DM_ARB_RR_EN`: req0 and req1 held high for 4 accesses -> grant order 0,1,0,1; without macro -> 0,0,0,0 and gnt1 never.
- Reset in WRB of a byte store to 0x030 (old 0xCAFEBABE) -> no gnt, mem_we=0, word still 0xCAFEBABE, state IDLE after reset.
- Idle bus: no req for 10 cycles -> busy=0, mem_we=0, all gnt 0.
